hqm_system_mem_pg_seq_2048x16: RTL and testbench
================================================

Name: hqm_system_mem_pg_seq_2048x16

Overview:
- Initiator-side controller for a power-gated 2048x16 system SRAM.
- Owns the SRAM power handshake: drives pgcb_isol_en and pwr_enable_b_in, and waits on pwr_enable_b_out.
- Gates client read/write traffic by power state.
- Sits between the hqm_system client logic and the SRAM wrapper; stalls accesses until the array is powered and de-isolated.

Parameters:
- RD_LAT, 1: SRAM read latency in clk cycles (re to rdata valid); legal range 1..3.
- SETTLE_CYC, 4: cycles held isolated after power-good before accesses open; legal range 1..15.
- PG_TIMEOUT, 255: cycles allowed for pwr_enable_b_out to follow pwr_enable_b_in before pg_err sets.

Ports:
- clk  in  1  functional clock
- clk_rst_n  in  1  reset; asynchronous assert, active-low
- pwr_down_req  in  1  level; 1 = client wants the array powered off
- pwr_is_on  out  1  1 only in state ON
- pg_err  out  1  sticky power-handshake timeout
- cl_re  in  1  client read request
- cl_we  in  1  client write request
- cl_addr  in  11  client address
- cl_wdata  in  16  client write data
- cl_rdy  out  1  access accepted this cycle
- cl_rvalid  out  1  read data valid
- cl_rdata  out  16  read data
- mem_re  out  1  SRAM read enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  11  SRAM address
- mem_wdata  out  16  SRAM write data
- mem_rdata  in  16  SRAM read data
- mem_pgcb_isol_en  out  1  SRAM isolation enable
- mem_pwr_enable_b_in  out  1  SRAM power enable, active-low
- mem_pwr_enable_b_out  in  1  SRAM power-good echo, active-low

Behaviour:
- Clocking and reset: one clock domain. Asynchronous active-low reset.
- Reset values: state=OFF, mem_pgcb_isol_en=1, mem_pwr_enable_b_in=1, pwr_is_on=0, pg_err=0, cl_rdy=0, cl_rvalid=0, cl_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0. Counters and the read pipeline clear to 0.
- State machine (registered):
  - OFF: isol=1, enable_b_in=1. If !pwr_down_req, go to PWRUP.
  - PWRUP: enable_b_in=0, isol=1. When mem_pwr_enable_b_out==0, go to SETTLE and load the settle counter.
  - SETTLE: isol=1. Count SETTLE_CYC cycles, then go to ON with isol=0.
  - ON: isol=0. If pwr_down_req, go to DRAIN.
  - DRAIN: no new accesses. Once the read pipeline is empty, go to ISOL.
  - ISOL: isol=1 for exactly one cycle, then go to PWRDN.
  - PWRDN: enable_b_in=1. When mem_pwr_enable_b_out==1, go to OFF.
  - pwr_down_req deasserting during DRAIN/ISOL/PWRDN does not abort the sequence; the controller completes to OFF, then re-powers.
- Access gating:
  - cl_rdy = (state==ON) & !pwr_down_req, combinational.
  - mem_we = cl_we & cl_rdy.
  - mem_re = cl_re & !cl_we & cl_rdy. Simultaneous re+we: the write wins, the read is dropped, and no rvalid is returned.
  - mem_addr and mem_wdata pass cl_addr and cl_wdata when an access is forwarded; otherwise they are 0.
- Read return:
  - A RD_LAT-deep valid shift register tracks forwarded reads.
  - cl_rvalid is asserted exactly RD_LAT cycles after mem_re. cl_rdata = mem_rdata when valid, else 0.
  - Back-to-back reads give back-to-back rvalids.
- Timeout:
  - A 16-bit counter runs while in PWRUP or PWRDN and clears on state change.
  - Reaching PG_TIMEOUT sets pg_err, which holds until reset. The FSM keeps waiting; there is no forced transition.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Any in-flight read is discarded with no rvalid.

Test Plan:
- Reset release with pwr_down_req=0, SRAM echoes enable_b_out one cycle after enable_b_in -> enable_b_in falls at cycle 1, isol falls and pwr_is_on=1 after 4 settle cycles, cl_rdy=1.
- In ON: write addr 0x7FF data 0xA5C3, then read 0x7FF -> mem_we for one cycle; cl_rvalid exactly 1 cycle after mem_re with cl_rdata=0xA5C3.
- In ON: cl_re at 0x010 in the same cycle pwr_down_req rises -> cl_rdy=0, no mem_re, state enters DRAIN, then ISOL (isol=1), then PWRDN (enable_b_in=1), then OFF.
- With RD_LAT=3: read issued, pwr_down_req asserted the next cycle -> DRAIN holds until cl_rvalid is seen, then ISOL.
- cl_re=cl_we=1 at addr 0x123 -> mem_we=1, mem_re=0, no cl_rvalid.
- SRAM never echoes in PWRUP -> pg_err=1 after 255 cycles, state stays PWRUP; the echo then arrives -> SETTLE, then ON, with pg_err still 1.

Source files
------------

// File: rtl/hqm_system_mem_pg_seq_2048x16.sv
// Power-gating sequencer and access gate for the hqm_system 2048x16 SRAM.
// Owns the isolation / power-enable handshake and stalls client traffic until the array is usable.
module hqm_system_mem_pg_seq_2048x16 #(
  parameter int RD_LAT     = 1,
  parameter int SETTLE_CYC = 4,
  parameter int PG_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clk_rst_n,
  input  logic        pwr_down_req,
  output logic        pwr_is_on,
  output logic        pg_err,
  input  logic        cl_re,
  input  logic        cl_we,
  input  logic [10:0] cl_addr,
  input  logic [15:0] cl_wdata,
  output logic        cl_rdy,
  output logic        cl_rvalid,
  output logic [15:0] cl_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_pgcb_isol_en,
  output logic        mem_pwr_enable_b_in,
  input  logic        mem_pwr_enable_b_out
);

  // state  | meaning
  // OFF    | array unpowered and isolated; waits for power-up request
  // PWRUP  | power enable driven, waiting for power-good echo
  // SETTLE | powered but still isolated for SETTLE_CYC cycles
  // ON     | de-isolated, client accesses forwarded
  // DRAIN  | no new accesses, waiting for outstanding reads to return
  // ISOL   | isolation re-asserted for one cycle before power removal
  // PWRDN  | power enable released, waiting for echo to follow
  typedef enum logic [2:0] {
    ST_OFF, ST_PWRUP, ST_SETTLE, ST_ON, ST_DRAIN, ST_ISOL, ST_PWRDN
  } state_t;

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [15:0] TMO_LOAD    = 16'(PG_TIMEOUT);

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [15:0]       tmo_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic              fwd;
  logic              tmo_hit;

  assign cl_rdy    = (state == ST_ON) && !pwr_down_req;
  assign mem_we    = cl_we & cl_rdy;
  assign mem_re    = cl_re & ~cl_we & cl_rdy;
  assign fwd       = mem_we | mem_re;
  assign mem_addr  = fwd ? cl_addr : '0;
  assign mem_wdata = fwd ? cl_wdata : '0;
  assign cl_rvalid = rd_pipe[RD_LAT-1];
  assign cl_rdata  = cl_rvalid ? mem_rdata : '0;
  assign tmo_hit   = (tmo_cnt == 16'd1);

  always_ff @(posedge clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= RD_LAT'({rd_pipe, mem_re});
    end
  end

  // Outputs are updated together with the transition so they always reflect the current state.
  always_ff @(posedge clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      state               <= ST_OFF;
      mem_pgcb_isol_en    <= 1'b1;
      mem_pwr_enable_b_in <= 1'b1;
      pwr_is_on           <= 1'b0;
      pg_err              <= 1'b0;
      settle_cnt          <= '0;
      tmo_cnt             <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (!pwr_down_req) begin
            state               <= ST_PWRUP;
            mem_pwr_enable_b_in <= 1'b0;
            tmo_cnt             <= TMO_LOAD;
          end
        end
        ST_PWRUP: begin
          if (!mem_pwr_enable_b_out) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
            tmo_cnt    <= '0;
          end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 16'd1;
            if (tmo_hit) pg_err <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state            <= ST_ON;
            mem_pgcb_isol_en <= 1'b0;
            pwr_is_on        <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_ON: begin
          if (pwr_down_req) begin
            state     <= ST_DRAIN;
            pwr_is_on <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (rd_pipe == '0) begin
            state            <= ST_ISOL;
            mem_pgcb_isol_en <= 1'b1;
          end
        end
        ST_ISOL: begin
          state               <= ST_PWRDN;
          mem_pwr_enable_b_in <= 1'b1;
          tmo_cnt             <= TMO_LOAD;
        end
        ST_PWRDN: begin
          if (mem_pwr_enable_b_out) begin
            state   <= ST_OFF;
            tmo_cnt <= '0;
          end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 16'd1;
            if (tmo_hit) pg_err <= 1'b1;
          end
        end
        default: begin
          state               <= ST_OFF;
          mem_pgcb_isol_en    <= 1'b1;
          mem_pwr_enable_b_in <= 1'b1;
          pwr_is_on           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hqm_system_mem_pg_seq_2048x16.sv
// Bench for hqm_system_mem_pg_seq_2048x16: vector table, directed corner sequences and a
// randomized run compared against a cycle-level reference model of the power sequence.
module tb_hqm_system_mem_pg_seq_2048x16;

  localparam int PG_TIMEOUT = 255;
  localparam int SETTLE_CYC = 4;
  localparam int M_OFF = 0, M_UP = 1, M_SET = 2, M_ON = 3, M_DRN = 4, M_ISO = 5, M_DN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clk_rst_n;
  logic        pwr_down_req, pwr_is_on, pg_err;
  logic        cl_re, cl_we, cl_rdy, cl_rvalid;
  logic [10:0] cl_addr, mem_addr;
  logic [15:0] cl_wdata, cl_rdata, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_pgcb_isol_en, mem_pwr_enable_b_in;
  logic        mem_pwr_enable_b_out = 1'b1;
  logic        hold_echo;

  logic        pwr_down_req_3, pwr_is_on_3, pg_err_3;
  logic        cl_re_3, cl_we_3, cl_rdy_3, cl_rvalid_3;
  logic [10:0] cl_addr_3, mem_addr_3;
  logic [15:0] cl_wdata_3, cl_rdata_3, mem_wdata_3, mem_rdata_3;
  logic        mem_re_3, mem_we_3, mem_pgcb_isol_en_3, mem_pwr_enable_b_in_3;
  logic        mem_pwr_enable_b_out_3 = 1'b1;

  hqm_system_mem_pg_seq_2048x16 #(.RD_LAT(1), .SETTLE_CYC(SETTLE_CYC), .PG_TIMEOUT(PG_TIMEOUT)) u_dut (
    .clk(clk), .clk_rst_n(clk_rst_n), .pwr_down_req(pwr_down_req), .pwr_is_on(pwr_is_on),
    .pg_err(pg_err), .cl_re(cl_re), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_rdy(cl_rdy), .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_pgcb_isol_en(mem_pgcb_isol_en), .mem_pwr_enable_b_in(mem_pwr_enable_b_in),
    .mem_pwr_enable_b_out(mem_pwr_enable_b_out));

  hqm_system_mem_pg_seq_2048x16 #(.RD_LAT(3), .SETTLE_CYC(SETTLE_CYC), .PG_TIMEOUT(PG_TIMEOUT)) u_dut3 (
    .clk(clk), .clk_rst_n(clk_rst_n), .pwr_down_req(pwr_down_req_3), .pwr_is_on(pwr_is_on_3),
    .pg_err(pg_err_3), .cl_re(cl_re_3), .cl_we(cl_we_3), .cl_addr(cl_addr_3), .cl_wdata(cl_wdata_3),
    .cl_rdy(cl_rdy_3), .cl_rvalid(cl_rvalid_3), .cl_rdata(cl_rdata_3), .mem_re(mem_re_3),
    .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3),
    .mem_pgcb_isol_en(mem_pgcb_isol_en_3), .mem_pwr_enable_b_in(mem_pwr_enable_b_in_3),
    .mem_pwr_enable_b_out(mem_pwr_enable_b_out_3));

  // SRAM and power-switch models; junk on rdata when no read returns checks the output gating.
  logic [15:0] sram  [0:2047] = '{default: 16'h0};
  logic [15:0] sram3 [0:2047] = '{default: 16'h0};
  logic [15:0] sram_q = 16'h0, d3_0 = 16'h0, d3_1 = 16'h0, d3_2 = 16'h0;
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    sram_q <= mem_re ? sram[mem_addr] : 16'hBEEF;
    if (mem_we_3) sram3[mem_addr_3] <= mem_wdata_3;
    d3_0 <= mem_re_3 ? sram3[mem_addr_3] : 16'hDEAD;
    d3_1 <= d3_0;
    d3_2 <= d3_1;
    mem_pwr_enable_b_out   <= hold_echo | mem_pwr_enable_b_in;
    mem_pwr_enable_b_out_3 <= mem_pwr_enable_b_in_3;
  end
  assign mem_rdata   = sram_q;
  assign mem_rdata_3 = d3_2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the power sequence, cycles spent in it, expected memory image
  // and a list of reads still owed to the client with the cycle each must come back.
  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t         pend[$];
  logic [15:0] m_mem [0:2047] = '{default: 16'h0};
  int          m_st, m_cnt, cyc;
  logic        m_err;

  task automatic model_reset();
    m_st = M_OFF; m_cnt = 0; m_err = 1'b0; cyc = 0;
    pend.delete();
  endtask

  task automatic step();
    logic e_rdy, e_re, e_we, e_rv, e_fwd;
    logic [15:0] e_rd;
    rd_t r;
    int nxt;
    @(negedge clk);
    e_rdy = (m_st == M_ON) && !pwr_down_req;
    e_we  = cl_we && e_rdy;
    e_re  = cl_re && !cl_we && e_rdy;
    e_fwd = e_we || e_re;
    e_rv  = (pend.size() > 0) && (pend[0].due == cyc);
    e_rd  = e_rv ? pend[0].data : 16'h0;
    chk("cl_rdy", cl_rdy, e_rdy);
    chk("mem_we", mem_we, e_we);
    chk("mem_re", mem_re, e_re);
    chk("mem_addr", mem_addr, e_fwd ? cl_addr : 11'h0);
    chk("mem_wdata", mem_wdata, e_fwd ? cl_wdata : 16'h0);
    chk("cl_rvalid", cl_rvalid, e_rv);
    chk("cl_rdata", cl_rdata, e_rd);
    chk("isol_en", mem_pgcb_isol_en, !(m_st == M_ON || m_st == M_DRN));
    chk("pwr_enable_b_in", mem_pwr_enable_b_in, (m_st == M_OFF || m_st == M_DN));
    chk("pwr_is_on", pwr_is_on, m_st == M_ON);
    chk("pg_err", pg_err, m_err);
    if (e_we) m_mem[cl_addr] = cl_wdata;
    if (e_re) begin
      r.due = cyc + 1; r.data = m_mem[cl_addr];
      pend.push_back(r);
    end
    if (e_rv) void'(pend.pop_front());
    nxt = m_st;
    case (m_st)
      M_OFF: if (!pwr_down_req) nxt = M_UP;
      M_UP:  if (!mem_pwr_enable_b_out) nxt = M_SET;
      M_SET: if (m_cnt + 1 == SETTLE_CYC) nxt = M_ON;
      M_ON:  if (pwr_down_req) nxt = M_DRN;
      M_DRN: if (pend.size() == 0 && !e_rv) nxt = M_ISO;
      M_ISO: nxt = M_DN;
      M_DN:  if (mem_pwr_enable_b_out) nxt = M_OFF;
      default: nxt = M_OFF;
    endcase
    if (nxt != m_st) m_cnt = 0;
    else begin
      m_cnt++;
      if ((m_st == M_UP || m_st == M_DN) && m_cnt == PG_TIMEOUT) m_err = 1'b1;
    end
    m_st = nxt;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clk_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    clk_rst_n = 1'b1;
  endtask

  task automatic wait_on(input int budget);
    int n = 0;
    while (!pwr_is_on && n < budget) begin
      step();
      n++;
    end
    chk("reach_on", pwr_is_on, 1'b1);
  endtask

  typedef struct {
    logic pdr, re, we; logic [10:0] addr; logic [15:0] wdata;
    logic rdy, mre, mwe; logic [10:0] maddr; logic [15:0] mwdata;
  } vec_t;
  vec_t vecs [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 11'h055, 16'h1111, 1'b1, 1'b0, 1'b0, 11'h000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 11'h010, 16'h2222, 1'b1, 1'b1, 1'b0, 11'h010, 16'h2222};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 11'h7FF, 16'hA5C3, 1'b1, 1'b0, 1'b1, 11'h7FF, 16'hA5C3};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 11'h123, 16'hBEEF, 1'b1, 1'b0, 1'b1, 11'h123, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 11'h010, 16'h3333, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 11'h400, 16'h4444, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000};

    pwr_down_req = 0; cl_re = 0; cl_we = 0; cl_addr = '0; cl_wdata = '0; hold_echo = 0;
    pwr_down_req_3 = 0; cl_re_3 = 0; cl_we_3 = 0; cl_addr_3 = '0; cl_wdata_3 = '0;
    do_reset();

    // Power-up timing from reset release with a one-cycle echo.
    step();
    chk("pu_enb_fall", mem_pwr_enable_b_in, 1'b0);
    chk("pu_isol_c1", mem_pgcb_isol_en, 1'b1);
    repeat (5) step();
    chk("pu_isol_c6", mem_pgcb_isol_en, 1'b1);
    chk("pu_on_c6", pwr_is_on, 1'b0);
    step();
    chk("pu_on_c7", pwr_is_on, 1'b1);
    chk("pu_isol_c7", mem_pgcb_isol_en, 1'b0);
    chk("pu_rdy_c7", cl_rdy, 1'b1);

    // RD_LAT=3 instance: read then power-down request, DRAIN must wait for the return.
    chk("l3_on", pwr_is_on_3, 1'b1);
    cl_we_3 = 1; cl_addr_3 = 11'h0AB; cl_wdata_3 = 16'h1357;
    #1 chk("l3_we", mem_we_3, 1'b1);
    step();
    cl_we_3 = 0; cl_re_3 = 1;
    #1 chk("l3_re", mem_re_3, 1'b1);
    step();
    cl_re_3 = 0; pwr_down_req_3 = 1;
    #1 chk("l3_rdy_drop", cl_rdy_3, 1'b0);
    chk("l3_rv_t1", cl_rvalid_3, 1'b0);
    step();
    chk("l3_rv_t2", cl_rvalid_3, 1'b0);
    chk("l3_drain_on", pwr_is_on_3, 1'b0);
    chk("l3_drain_isol_t2", mem_pgcb_isol_en_3, 1'b0);
    step();
    chk("l3_rv_t3", cl_rvalid_3, 1'b1);
    chk("l3_rdata_t3", cl_rdata_3, 16'h1357);
    chk("l3_drain_isol_t3", mem_pgcb_isol_en_3, 1'b0);
    step();
    chk("l3_rv_t4", cl_rvalid_3, 1'b0);
    chk("l3_rdata_t4", cl_rdata_3, 16'h0);
    chk("l3_drain_isol_t4", mem_pgcb_isol_en_3, 1'b0);
    step();
    chk("l3_isol", mem_pgcb_isol_en_3, 1'b1);
    chk("l3_isol_enb", mem_pwr_enable_b_in_3, 1'b0);
    step();
    chk("l3_pwrdn_enb", mem_pwr_enable_b_in_3, 1'b1);

    // Combinational gating table, applied and removed between clock edges.
    for (int i = 0; i < 6; i++) begin
      pwr_down_req = vecs[i].pdr; cl_re = vecs[i].re; cl_we = vecs[i].we;
      cl_addr = vecs[i].addr; cl_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdy", i), cl_rdy, vecs[i].rdy);
      chk($sformatf("vec%0d_re", i), mem_re, vecs[i].mre);
      chk($sformatf("vec%0d_we", i), mem_we, vecs[i].mwe);
      chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].maddr);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].mwdata);
    end
    pwr_down_req = 0; cl_re = 0; cl_we = 0; cl_addr = '0; cl_wdata = '0;
    #1;

    // Write then read back at the top address.
    cl_we = 1; cl_addr = 11'h7FF; cl_wdata = 16'hA5C3;
    #1 chk("wr_mem_we", mem_we, 1'b1);
    step();
    cl_we = 0; cl_re = 1;
    #1 chk("rd_mem_re", mem_re, 1'b1);
    step();
    cl_re = 0;
    #1 chk("rd_rvalid", cl_rvalid, 1'b1);
    chk("rd_rdata", cl_rdata, 16'hA5C3);
    step();
    chk("rd_rvalid_once", cl_rvalid, 1'b0);

    // Simultaneous read and write: write wins, no read return.
    cl_re = 1; cl_we = 1; cl_addr = 11'h123; cl_wdata = 16'h0F0F;
    #1 chk("rw_we", mem_we, 1'b1);
    chk("rw_re", mem_re, 1'b0);
    step();
    cl_re = 0; cl_we = 0;
    #1 chk("rw_no_rvalid", cl_rvalid, 1'b0);
    step();

    // Power-down request arriving with a read: blocked, then DRAIN/ISOL/PWRDN/OFF.
    pwr_down_req = 1; cl_re = 1; cl_addr = 11'h010;
    #1 chk("pd_rdy", cl_rdy, 1'b0);
    chk("pd_re", mem_re, 1'b0);
    step();
    cl_re = 0;
    chk("pd_drain_on", pwr_is_on, 1'b0);
    chk("pd_drain_isol", mem_pgcb_isol_en, 1'b0);
    step();
    chk("pd_isol", mem_pgcb_isol_en, 1'b1);
    chk("pd_isol_enb", mem_pwr_enable_b_in, 1'b0);
    step();
    chk("pd_pwrdn_enb", mem_pwr_enable_b_in, 1'b1);
    repeat (5) step();
    chk("pd_off_enb", mem_pwr_enable_b_in, 1'b1);
    pwr_down_req = 0;
    wait_on(40);

    // Asynchronous reset with a read in flight.
    cl_re = 1; cl_addr = 11'h055;
    step();
    cl_re = 0;
    clk_rst_n = 1'b0;
    #1 chk("rst_rvalid", cl_rvalid, 1'b0);
    chk("rst_rdata", cl_rdata, 16'h0);
    chk("rst_on", pwr_is_on, 1'b0);
    chk("rst_isol", mem_pgcb_isol_en, 1'b1);
    chk("rst_enb", mem_pwr_enable_b_in, 1'b1);
    chk("rst_rdy", cl_rdy, 1'b0);
    do_reset();
    repeat (3) step();

    // Power-good echo withheld: sticky pg_err after PG_TIMEOUT cycles, no forced exit.
    hold_echo = 1;
    do_reset();
    repeat (PG_TIMEOUT) step();
    chk("tmo_before", pg_err, 1'b0);
    step();
    chk("tmo_set", pg_err, 1'b1);
    chk("tmo_still_pwrup", mem_pwr_enable_b_in, 1'b0);
    repeat (10) step();
    hold_echo = 0;
    wait_on(20);
    chk("tmo_sticky", pg_err, 1'b1);

    // Randomized traffic with occasional power-down requests.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) pwr_down_req = !pwr_down_req;
      cl_re = 1'($urandom_range(0, 1));
      cl_we = ($urandom_range(0, 3) == 0);
      cl_addr = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      cl_wdata = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
